// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_arbiter
// Brief    : Merges the core's fetch and data ports onto one single-beat
//            memory port, with one transaction in flight. Responses to
//            withdrawn or changed requests are suppressed.
//            Optional macro ARB_RR_EN selects round-robin priority; without
//            it the data port always wins a collision.
// Revision : 1.0 - initial release
// ============================================================================

package core_bus_pkg;
    localparam int unsigned CORE_ADDR_W = 64;
    localparam int unsigned CORE_DATA_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [CORE_ADDR_W-1:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [CORE_DATA_W-1:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic                     valid;
        logic [CORE_ADDR_W-1:0]   addr;
        logic [2:0]               size;
        logic [CORE_DATA_W/8-1:0] strobe;
        logic [CORE_DATA_W-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic                   addr_ok;
        logic                   data_ok;
        logic [CORE_DATA_W-1:0] data;
    } dbus_resp_t;
endpackage

module core_bus_arbiter
    import core_bus_pkg::*;
#(
    parameter int unsigned ADDR_W = CORE_ADDR_W,
    parameter int unsigned DATA_W = CORE_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  ibus_req_t           ireq,
    output ibus_resp_t          iresp,
    input  dbus_req_t           dreq,
    output dbus_resp_t          dresp,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_write,
    output logic [2:0]          mem_size,
    output logic [DATA_W/8-1:0] mem_strobe,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_IBUSY = 2'd1;
    localparam logic [1:0] c_ST_DBUSY = 2'd2;
    localparam logic [2:0] c_FETCH_SIZE = 3'b011;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_stale;
    logic                w_stale_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_size;
    logic [DATA_W/8-1:0] r_strobe;
    logic [DATA_W-1:0]   r_wdata;

    logic w_d_wins;
    logic w_i_wins;
    logic w_capture_i;
    logic w_capture_d;
    logic w_i_mismatch;
    logic w_d_mismatch;
    logic w_i_done;
    logic w_d_done;

`ifdef ARB_RR_EN
    // 1 = data port was granted last, 0 = fetch port
    logic r_last_grant;

    assign w_d_wins = dreq.valid && (!ireq.valid || !r_last_grant);
`else
    assign w_d_wins = dreq.valid;
`endif
    assign w_i_wins = ireq.valid && !w_d_wins;

    // Any change to the owning request while in flight marks it as abandoned
    assign w_i_mismatch = !ireq.valid || (ireq.addr != r_addr);
    assign w_d_mismatch = !dreq.valid || (dreq.addr != r_addr)
                       || (dreq.strobe != r_strobe) || (dreq.data != r_wdata);

    always_comb begin
        w_state_nxt = r_state;
        w_stale_nxt = r_stale;
        w_capture_i = 1'b0;
        w_capture_d = 1'b0;
        w_i_done    = 1'b0;
        w_d_done    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_d_wins) begin
                    w_state_nxt = c_ST_DBUSY;
                    w_capture_d = 1'b1;
                end else if (w_i_wins) begin
                    w_state_nxt = c_ST_IBUSY;
                    w_capture_i = 1'b1;
                end
            end
            c_ST_IBUSY: begin
                if (mem_ready) begin
                    w_state_nxt = c_ST_IDLE;
                    w_stale_nxt = 1'b0;
                    w_i_done    = !r_stale && !w_i_mismatch;
                end else if (w_i_mismatch) begin
                    w_stale_nxt = 1'b1;
                end
            end
            c_ST_DBUSY: begin
                if (mem_ready) begin
                    w_state_nxt = c_ST_IDLE;
                    w_stale_nxt = 1'b0;
                    w_d_done    = !r_stale && !w_d_mismatch;
                end else if (w_d_mismatch) begin
                    w_stale_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_stale_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_ST_IDLE;
            r_stale  <= 1'b0;
            r_addr   <= '0;
            r_size   <= '0;
            r_strobe <= '0;
            r_wdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stale <= w_stale_nxt;
            if (w_capture_d) begin
                r_addr   <= dreq.addr;
                r_size   <= dreq.size;
                r_strobe <= dreq.strobe;
                r_wdata  <= dreq.data;
            end else if (w_capture_i) begin
                r_addr   <= ireq.addr;
                r_size   <= c_FETCH_SIZE;
                r_strobe <= '0;
                r_wdata  <= '0;
            end
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b0;
        end else if (w_capture_d) begin
            r_last_grant <= 1'b1;
        end else if (w_capture_i) begin
            r_last_grant <= 1'b0;
        end
    end
`endif

    assign mem_valid  = (r_state != c_ST_IDLE);
    assign mem_addr   = r_addr;
    assign mem_write  = |r_strobe;
    assign mem_size   = r_size;
    assign mem_strobe = r_strobe;
    assign mem_wdata  = r_wdata;

    // Responses are combinational so they land in the mem_ready cycle
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (w_i_done) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = mem_rdata;
        end
        if (w_d_done) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = mem_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_bus_arbiter
// Brief    : Directed bench for core_bus_arbiter with a response scoreboard
//            and a small wait-state memory model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_core_bus_arbiter;
    import core_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    dbus_req_t   dreq;
    dbus_resp_t  dresp;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic        mem_write;
    logic [2:0]  mem_size;
    logic [7:0]  mem_strobe;
    logic [63:0] mem_wdata;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    typedef struct {
        bit          is_d;
        logic [63:0] data;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     n_vec = 0;
    int     n_err = 0;
    int     n_iresp = 0;
    int     n_dresp = 0;
    longint cyc = 0;
    longint last_resp_cyc = 0;
    longint prev_cyc = 0;
    int     mem_waits = 0;
    bit     mem_force = 1'b0;
    int     wait_cnt = 0;
    int     tgt;
    bit     first_d;

    core_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .ireq       (ireq),
        .iresp      (iresp),
        .dreq       (dreq),
        .dresp      (dresp),
        .mem_valid  (mem_valid),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_strobe (mem_strobe),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h00000013_00000093;
        return {a[31:0] ^ 32'hA5A5_5A5A, ~a[31:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Wait (bounded) until the port's response count reaches target, then
    // step into the following idle cycle.
    task automatic wait_resp(input bit is_d, input int target, input string tag);
        int c = 0;
        #1;
        while (((is_d ? n_dresp : n_iresp) < target) && (c < 50)) begin
            @(negedge clk);
            #1;
            c++;
        end
        check(tag, 64'(is_d ? n_dresp : n_iresp), 64'(target));
        @(posedge clk);
        #1;
    endtask

    // Memory model: completes after mem_waits wait cycles
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (mem_force) begin
                mem_ready = 1'b1;
                mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (mem_valid) begin
                if (wait_cnt >= mem_waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = '0;
                    wait_cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
                wait_cnt  = 0;
            end
        end
    end

    // Response monitor / scoreboard consumer
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (iresp.data_ok || dresp.data_ok) begin
                    last_resp_cyc = cyc;
                    if (iresp.data_ok) n_iresp++;
                    if (dresp.data_ok) n_dresp++;
                    if (sb_q.size() == 0) begin
                        check("spurious_resp", 64'({iresp.data_ok, dresp.data_ok}), 64'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("resp_port", 64'({iresp.data_ok, dresp.data_ok}),
                              mon_e.is_d ? 64'd1 : 64'd2);
                        check("resp_addr_ok", 64'({iresp.addr_ok, dresp.addr_ok}),
                              mon_e.is_d ? 64'd1 : 64'd2);
                        check("resp_data", mon_e.is_d ? dresp.data : iresp.data, mon_e.data);
                    end
                end
                if (!iresp.data_ok)
                    check("iresp_quiet", iresp.data | 64'(iresp.addr_ok), 64'd0);
                if (!dresp.data_ok)
                    check("dresp_quiet", dresp.data | 64'(dresp.addr_ok), 64'd0);
            end
        end
    end

    initial begin
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_strobe", 64'(mem_strobe), 64'd0);
        check("rst_iresp", iresp.data | 64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
        check("rst_dresp", dresp.data | 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Zero-wait fetch: response in the cycle after the request
        @(posedge clk);
        #1;
        mem_waits = 0;
        tgt = n_iresp + 1;
        ireq = '{valid: 1'b1, addr: 64'h8000_0000};
        sb_q.push_back('{is_d: 1'b0, data: 64'h00000013_00000093});
        @(posedge clk);
        @(negedge clk);
        #1;
        check("fetch_mem_valid", 64'(mem_valid), 64'd1);
        check("fetch_mem_addr", mem_addr, 64'h8000_0000);
        check("fetch_mem_strobe", 64'(mem_strobe), 64'd0);
        check("fetch_mem_size", 64'(mem_size), 64'd3);
        check("fetch_mem_write", 64'(mem_write), 64'd0);
        check("fetch_zero_wait", 64'(n_iresp), 64'(tgt));
        wait_resp(1'b0, tgt, "fetch_done");
        ireq = '0;

        // Redirect while a fetch is outstanding
        mem_waits = 2;
        @(posedge clk);
        #1;
        ireq = '{valid: 1'b1, addr: 64'h8000_0010};
        @(posedge clk);
        #1;
        ireq.addr = 64'h8000_0100;
        tgt = n_iresp + 1;
        sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0100)});
        @(negedge clk);
        check("redirect_hold_addr", mem_addr, 64'h8000_0010);
        wait_resp(1'b0, tgt, "redirect_done");
        ireq = '0;

        // Store with three wait cycles
        mem_waits = 3;
        tgt = n_dresp + 1;
        dreq = '{valid: 1'b1, addr: 64'h8000_2000, size: 3'b010, strobe: 8'h0F,
                 data: 64'hDEAD_BEEF};
        sb_q.push_back('{is_d: 1'b1, data: mem_model(64'h8000_2000)});
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("store_mem_valid", 64'(mem_valid), 64'd1);
            check("store_mem_write", 64'(mem_write), 64'd1);
            check("store_mem_addr", mem_addr, 64'h8000_2000);
            check("store_mem_strobe", 64'(mem_strobe), 64'h0F);
            check("store_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
            check("store_mem_size", 64'(mem_size), 64'd2);
        end
        wait_resp(1'b1, tgt, "store_done");
        dreq = '0;
        repeat (3) @(negedge clk);
        check("store_single_pulse", 64'(n_dresp), 64'(tgt));

        // Collision: both ports valid in the same idle cycle
        mem_waits = 0;
        @(posedge clk);
        #1;
`ifdef ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        ireq = '{valid: 1'b1, addr: 64'h8000_0004};
        dreq = '{valid: 1'b1, addr: 64'h8000_1000, size: 3'b011, strobe: 8'h00, data: 64'd0};
        if (first_d) begin
            sb_q.push_back('{is_d: 1'b1, data: mem_model(64'h8000_1000)});
            sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0004)});
        end else begin
            sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0004)});
            sb_q.push_back('{is_d: 1'b1, data: mem_model(64'h8000_1000)});
        end
        wait_resp(first_d, (first_d ? n_dresp : n_iresp) + 1, "collision_first");
        if (first_d) dreq = '0;
        else         ireq = '0;
        @(negedge clk);
        check("collision_idle_gap", 64'(mem_valid), 64'd0);
        wait_resp(!first_d, (first_d ? n_iresp : n_dresp) + 1, "collision_second");
        ireq = '0;
        dreq = '0;

        // Back-to-back fetches: one response every two cycles
        mem_waits = 0;
        @(posedge clk);
        #1;
        tgt = n_iresp + 1;
        ireq = '{valid: 1'b1, addr: 64'h8000_0200};
        sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0200)});
        for (int k = 0; k < 4; k++) begin
            wait_resp(1'b0, tgt, "b2b_done");
            if (k > 0) check("b2b_gap", 64'(last_resp_cyc - prev_cyc), 64'd2);
            prev_cyc = last_resp_cyc;
            if (k < 3) begin
                ireq.addr = 64'h8000_0200 + 64'(8 * (k + 1));
                sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0200 + 64'(8 * (k + 1)))});
                tgt++;
            end else begin
                ireq = '0;
            end
        end

        // mem_ready while idle must be ignored
        mem_force = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_ready_no_valid", 64'(mem_valid), 64'd0);
        end
        mem_force = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a store
        mem_waits = 5;
        dreq = '{valid: 1'b1, addr: 64'h8000_3000, size: 3'b011, strobe: 8'hFF,
                 data: 64'h1122_3344_5566_7788};
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_pre_valid", 64'(mem_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_valid", 64'(mem_valid), 64'd0);
        check("rst_async_addr", mem_addr, 64'd0);
        check("rst_async_write", 64'(mem_write), 64'd0);
        check("rst_async_dresp", dresp.data | 64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
        dreq = '0;
        @(posedge clk);
        #1 reset = 1'b1;

        // Recovery fetch after reset
        mem_waits = 1;
        @(posedge clk);
        #1;
        tgt = n_iresp + 1;
        ireq = '{valid: 1'b1, addr: 64'h8000_0040};
        sb_q.push_back('{is_d: 1'b0, data: mem_model(64'h8000_0040)});
        wait_resp(1'b0, tgt, "recover_done");
        ireq = '0;

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
